// File: rtl/mux_scan_reg.sv
// mux_scan_reg: registered N-way bus multiplexer with an autonomous scan mode.
// Direct mode registers channel[sel] each enabled cycle. Scan mode steps
// channels 0..scanLast once, emitting one tagged sample per enabled cycle.
module mux_scan_reg #(
   parameter int                WIDTH       = 1,
   parameter int                SEL_BITS    = 3,
   parameter logic [WIDTH-1:0]  RESET_VALUE = '0
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clockEnable,
   input  logic [(2**SEL_BITS)*WIDTH-1:0] muxIn,
   input  logic [SEL_BITS-1:0]          sel,
   input  logic                         mode,
   input  logic                         scanStart,
   input  logic [SEL_BITS-1:0]          scanLast,
   output logic [WIDTH-1:0]             muxOut,
   output logic [SEL_BITS-1:0]          outSel,
   output logic                         outValid,
   output logic                         scanBusy,
   output logic                         scanDone
);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_SCAN = 1'b1
   } state_t;

   state_t               state_q,     state_d;
   logic [SEL_BITS-1:0]  ptr_q,       ptr_d;
   logic [SEL_BITS-1:0]  last_q,      last_d;
   logic [WIDTH-1:0]     mux_out_q,   mux_out_d;
   logic [SEL_BITS-1:0]  out_sel_q,   out_sel_d;
   logic                 out_valid_q, out_valid_d;
   logic                 scan_done_q, scan_done_d;

   // Next-state and capture logic for both the direct path and the scan FSM.
   always_comb begin
      // NOTE: every signal assigned here gets a default first, so no path
      // through the case/if tree can leave it unassigned and infer a latch.
      state_d     = state_q;
      ptr_d       = ptr_q;
      last_d      = last_q;
      mux_out_d   = mux_out_q;
      out_sel_d   = out_sel_q;
      out_valid_d = 1'b0;
      scan_done_d = 1'b0;

      if (clockEnable) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!mode) begin
                  // Direct capture; scanStart has no meaning here.
                  mux_out_d   = muxIn[int'(sel)*WIDTH +: WIDTH];
                  out_sel_d   = sel;
                  out_valid_d = 1'b1;
               end else if (scanStart) begin
                  // Start cycle: latch the end channel, no sample yet.
                  last_d  = scanLast;
                  ptr_d   = '0;
                  state_d = ST_SCAN;
               end
            end
            ST_SCAN: begin
               mux_out_d   = muxIn[int'(ptr_q)*WIDTH +: WIDTH];
               out_sel_d   = ptr_q;
               out_valid_d = 1'b1;
               if (ptr_q == last_q) begin
                  // Last sample: compare before increment so the all-ones
                  // index terminates without the pointer ever wrapping.
                  scan_done_d = 1'b1;
                  ptr_d       = '0;
                  state_d     = ST_IDLE;
               end else begin
                  ptr_d = ptr_q + 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   // State and output registers with synchronous reset overriding clockEnable.
   always_ff @(posedge clock) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (reset) begin
         state_q     <= ST_IDLE;
         ptr_q       <= '0;
         last_q      <= '0;
         mux_out_q   <= RESET_VALUE;
         out_sel_q   <= '0;
         out_valid_q <= 1'b0;
         scan_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         last_q      <= last_d;
         mux_out_q   <= mux_out_d;
         out_sel_q   <= out_sel_d;
         out_valid_q <= out_valid_d;
         scan_done_q <= scan_done_d;
      end
   end

   // All outputs come straight from registers; busy is the decoded FSM state.
   assign muxOut   = mux_out_q;
   assign outSel   = out_sel_q;
   assign outValid = out_valid_q;
   assign scanBusy = (state_q == ST_SCAN);
   assign scanDone = scan_done_q;

endmodule

// File: tb/tb_mux_scan_reg.sv
// tb_mux_scan_reg: directed bench for mux_scan_reg (WIDTH=8, SEL_BITS=3).
// A queue-based reference model is compared every cycle; literal checks pin
// the model at the points the behaviour is easy to compute by hand.
module tb_mux_scan_reg;

   localparam int         WIDTH    = 8;
   localparam int         SEL_BITS = 3;
   localparam int         CHANNELS = 2**SEL_BITS;
   localparam logic [7:0] RST_VAL  = 8'hA5;

   logic                        clock = 1'b0;
   logic                        reset;
   logic                        clockEnable;
   logic [CHANNELS*WIDTH-1:0]   mux_in;
   logic [SEL_BITS-1:0]         sel;
   logic                        mode;
   logic                        scanStart;
   logic [SEL_BITS-1:0]         scanLast;
   logic [WIDTH-1:0]            muxOut;
   logic [SEL_BITS-1:0]         outSel;
   logic                        outValid;
   logic                        scanBusy;
   logic                        scanDone;

   int checks = 0;
   int errors = 0;

   mux_scan_reg #(
      .WIDTH      (WIDTH),
      .SEL_BITS   (SEL_BITS),
      .RESET_VALUE(RST_VAL)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .clockEnable(clockEnable),
      .muxIn      (mux_in),
      .sel        (sel),
      .mode       (mode),
      .scanStart  (scanStart),
      .scanLast   (scanLast),
      .muxOut     (muxOut),
      .outSel     (outSel),
      .outValid   (outValid),
      .scanBusy   (scanBusy),
      .scanDone   (scanDone)
   );

   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a scan is a queue of channel indices still to be emitted.
   int          pending[$];
   logic [7:0]  exp_out;
   int          exp_sel;
   bit          exp_valid;
   bit          exp_busy;
   bit          exp_done;
   bit          ready = 1'b0;

   function automatic logic [7:0] chan(input int idx);
      return mux_in[idx*WIDTH +: WIDTH];
   endfunction

   // Model update on every rising edge from the inputs held across that edge.
   always @(posedge clock) begin
      exp_valid = 1'b0;
      exp_done  = 1'b0;
      if (reset) begin
         pending.delete();
         exp_out = RST_VAL;
         exp_sel = 0;
      end else if (clockEnable) begin
         if (pending.size() > 0) begin
            exp_sel   = pending.pop_front();
            exp_out   = chan(exp_sel);
            exp_valid = 1'b1;
            exp_done  = (pending.size() == 0);
         end else if (!mode) begin
            exp_sel   = int'(sel);
            exp_out   = chan(exp_sel);
            exp_valid = 1'b1;
         end else if (scanStart) begin
            for (int i = 0; i <= int'(scanLast); i++) pending.push_back(i);
         end
      end
      exp_busy = (pending.size() > 0);
      ready    = 1'b1;
   end

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clock) begin
      if (ready) begin
         check("model muxOut",   32'(muxOut),   32'(exp_out));
         check("model outSel",   32'(outSel),   32'(exp_sel));
         check("model outValid", 32'(outValid), 32'(exp_valid));
         check("model scanBusy", 32'(scanBusy), 32'(exp_busy));
         check("model scanDone", 32'(scanDone), 32'(exp_done));
      end
   end

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic expect_out(input string name, input logic [7:0] mo, input int os,
                             input bit ov, input bit bz, input bit dn);
      check({name, " muxOut"},   32'(muxOut),   32'(mo));
      check({name, " outSel"},   32'(outSel),   32'(os));
      check({name, " outValid"}, 32'(outValid), 32'(ov));
      check({name, " scanBusy"}, 32'(scanBusy), 32'(bz));
      check({name, " scanDone"}, 32'(scanDone), 32'(dn));
   endtask

   task automatic load_pattern();
      for (int k = 0; k < CHANNELS; k++) mux_in[k*WIDTH +: WIDTH] = 8'h10 + 8'(k);
   endtask

   initial begin
      // Reset with clockEnable low and random other inputs.
      reset       = 1'b1;
      clockEnable = 1'b0;
      mux_in      = {$urandom, $urandom};
      sel         = 3'($urandom);
      mode        = 1'($urandom);
      scanStart   = 1'($urandom);
      scanLast    = 3'($urandom);
      step();
      step();
      expect_out("reset", RST_VAL, 0, 1'b0, 1'b0, 1'b0);

      // Direct mode captures with one cycle of latency.
      load_pattern();
      reset       = 1'b0;
      clockEnable = 1'b1;
      mode        = 1'b0;
      scanStart   = 1'b1;   // ignored in direct mode
      sel         = 3'd5;
      step();
      expect_out("direct sel5", 8'h15, 5, 1'b1, 1'b0, 1'b0);
      sel = 3'd7;
      step();
      expect_out("direct sel7", 8'h17, 7, 1'b1, 1'b0, 1'b0);

      // Stall: outputs hold, no strobe, sel changes are not captured.
      clockEnable = 1'b0;
      for (int i = 0; i < 3; i++) begin
         sel = 3'(i + 1);
         step();
         expect_out("stall", 8'h17, 7, 1'b0, 1'b0, 1'b0);
      end
      clockEnable = 1'b1;
      sel         = 3'd4;
      step();
      expect_out("after stall", 8'h14, 4, 1'b1, 1'b0, 1'b0);

      // Scan 0..3: start cycle yields no sample.
      mode      = 1'b1;
      scanStart = 1'b1;
      scanLast  = 3'd3;
      step();
      expect_out("scan3 start", 8'h14, 4, 1'b0, 1'b1, 1'b0);
      scanStart = 1'b0;
      scanLast  = 3'd1;   // ignored once latched
      sel       = 3'd6;
      for (int i = 0; i < 4; i++) begin
         step();
         expect_out("scan3 sample", 8'h10 + 8'(i), i, 1'b1, (i != 3), (i == 3));
      end

      // Scan mode, idle, no start: nothing captured.
      step();
      expect_out("scan idle", 8'h13, 3, 1'b0, 1'b0, 1'b0);

      // Full-range scan with scanStart held high, then immediate restart.
      scanStart = 1'b1;
      scanLast  = 3'd7;
      step();
      scanLast  = 3'd2;   // becomes the end channel of the restarted scan
      for (int i = 0; i < 8; i++) begin
         step();
         expect_out("scan7 sample", 8'h10 + 8'(i), i, 1'b1, (i != 7), (i == 7));
      end
      step();
      expect_out("restart start", 8'h17, 7, 1'b0, 1'b1, 1'b0);
      scanStart = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         expect_out("restart sample", 8'h10 + 8'(i), i, 1'b1, (i != 2), (i == 2));
      end

      // Single-channel scan: one sample carrying scanDone.
      scanStart = 1'b1;
      scanLast  = 3'd0;
      step();
      scanStart = 1'b0;
      step();
      expect_out("scan0 sample", 8'h10, 0, 1'b1, 1'b0, 1'b1);
      step();
      expect_out("scan0 after", 8'h10, 0, 1'b0, 1'b0, 1'b0);

      // Reset aborts a scan after three samples, with no scanDone.
      scanStart = 1'b1;
      scanLast  = 3'd6;
      step();
      scanStart = 1'b0;
      for (int i = 0; i < 3; i++) step();
      expect_out("pre abort", 8'h12, 2, 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      step();
      expect_out("abort reset", RST_VAL, 0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      step();
      expect_out("abort idle", RST_VAL, 0, 1'b0, 1'b0, 1'b0);
      mode = 1'b0;
      sel  = 3'd6;
      step();
      expect_out("post abort direct", 8'h16, 6, 1'b1, 1'b0, 1'b0);

      // Mixed random traffic, checked by the model only.
      for (int i = 0; i < 200; i++) begin
         reset       = ($urandom_range(0, 39) == 0);
         clockEnable = ($urandom_range(0, 3) != 0);
         mode        = 1'($urandom);
         scanStart   = 1'($urandom);
         scanLast    = 3'($urandom);
         sel         = 3'($urandom);
         mux_in      = {$urandom, $urandom};
         step();
      end

      @(negedge clock);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
